// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - LoongArch32 execute stage: ALU, single-cycle multiply, iterative divide, data-SRAM request
module exe_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_to_exe_valid,
  output logic        exe_allowin,
  input  logic [31:0] id_pc,
  input  logic [82:0] id_alu_data_zip,
  input  logic        id_res_from_mem,
  input  logic        id_mem_we,
  input  logic [31:0] id_rkd_value,
  input  logic [5:0]  id_rf_zip,
  input  logic        mem_allowin,
  output logic        exe_to_mem_valid,
  output logic [31:0] exe_pc,
  output logic [31:0] exe_alu_result,
  output logic        exe_res_from_mem,
  output logic [5:0]  exe_rf_zip,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic        exe_valid;
  logic [31:0] pc_r;
  logic [18:0] alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        res_from_mem_r;
  logic        mem_we_r;
  logic [31:0] rkd_value_r;
  logic [5:0]  rf_zip_r;

  div_state_t  div_state;
  div_state_t  div_state_nxt;
  logic [31:0] dvd_q;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  cnt;

  logic        is_div;
  logic        div_signed;
  logic        exe_ready_go;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] result;

  assign is_div       = |alu_op[18:15];
  assign div_signed   = alu_op[15] | alu_op[17];
  assign exe_ready_go = ~is_div | (div_state == DONE);
  assign exe_allowin  = ~exe_valid | (exe_ready_go & mem_allowin);
  assign exe_to_mem_valid = exe_valid & exe_ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid <= 1'b0;
    end else if (exe_allowin) begin
      exe_valid <= id_to_exe_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r           <= 32'd0;
      alu_op         <= 19'd0;
      src1           <= 32'd0;
      src2           <= 32'd0;
      res_from_mem_r <= 1'b0;
      mem_we_r       <= 1'b0;
      rkd_value_r    <= 32'd0;
      rf_zip_r       <= 6'd0;
    end else if (id_to_exe_valid && exe_allowin) begin
      pc_r           <= id_pc;
      alu_op         <= id_alu_data_zip[82:64];
      src1           <= id_alu_data_zip[63:32];
      src2           <= id_alu_data_zip[31:0];
      res_from_mem_r <= id_res_from_mem;
      mem_we_r       <= id_mem_we;
      rkd_value_r    <= id_rkd_value;
      rf_zip_r       <= id_rf_zip;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) div_state <= IDLE;
    else         div_state <= div_state_nxt;
  end

  always_comb begin
    div_state_nxt = div_state;
    case (div_state)
      IDLE: if (exe_valid && is_div) div_state_nxt = BUSY;
      BUSY: if (cnt == 5'd31) div_state_nxt = DONE;
      DONE: if (exe_to_mem_valid && mem_allowin) div_state_nxt = IDLE;
      default: div_state_nxt = IDLE;
    endcase
  end

  // Restoring step: the dividend shifts out MSB-first while quotient bits shift in.
  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  assign shifted = {rem, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[32];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd_q <= 32'd0;
      dvs   <= 32'd0;
      rem   <= 32'd0;
      cnt   <= 5'd0;
    end else if (div_state == IDLE) begin
      if (exe_valid && is_div) begin
        dvd_q <= (div_signed && src1[31]) ? -src1 : src1;
        dvs   <= (div_signed && src2[31]) ? -src2 : src2;
        rem   <= 32'd0;
        cnt   <= 5'd0;
      end
    end else if (div_state == BUSY) begin
      rem   <= q_bit ? diff[31:0] : shifted[31:0];
      dvd_q <= {dvd_q[30:0], q_bit};
      cnt   <= cnt + 5'd1;
    end
  end

  assign div_q = (div_signed && (src1[31] ^ src2[31])) ? -dvd_q : dvd_q;
  assign div_r = (div_signed && src1[31]) ? -rem : rem;

  assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  always_comb begin
    result = 32'd0;
    case (1'b1)
      alu_op[0]:  result = src1 + src2;
      alu_op[1]:  result = src1 - src2;
      alu_op[2]:  result = {31'd0, $signed(src1) < $signed(src2)};
      alu_op[3]:  result = {31'd0, src1 < src2};
      alu_op[4]:  result = src1 & src2;
      alu_op[5]:  result = ~(src1 | src2);
      alu_op[6]:  result = src1 | src2;
      alu_op[7]:  result = src1 ^ src2;
      alu_op[8]:  result = src1 << src2[4:0];
      alu_op[9]:  result = src1 >> src2[4:0];
      alu_op[10]: result = $signed(src1) >>> src2[4:0];
      alu_op[11]: result = src2;
      alu_op[12]: result = prod_s[31:0];
      alu_op[13]: result = prod_s[63:32];
      alu_op[14]: result = prod_u[63:32];
      alu_op[15]: result = div_q;
      alu_op[16]: result = div_q;
      alu_op[17]: result = div_r;
      alu_op[18]: result = div_r;
      default:    result = 32'd0;
    endcase
  end

  assign exe_pc           = pc_r;
  assign exe_alu_result   = result;
  assign exe_res_from_mem = res_from_mem_r & exe_valid;
  assign exe_rf_zip       = {rf_zip_r[5] & exe_valid, rf_zip_r[4:0]};
  assign data_sram_en     = exe_valid & mem_allowin & (res_from_mem_r | mem_we_r);
  assign data_sram_we     = {4{exe_valid & mem_allowin & mem_we_r}};
  assign data_sram_addr   = result;
  assign data_sram_wdata  = rkd_value_r;

endmodule
